// File: rtl/player_missile.sv
// Player missile: launches on a fire edge, climbs once per frame, and reports the
// lowest-index live enemy whose box it overlaps with a one-cycle hit pulse.
module player_missile #(
    parameter int          num_enemies_p     = 4,
    parameter logic [9:0]  missile_width_p   = 10'd4,
    parameter logic [9:0]  missile_height_p  = 10'd10,
    parameter logic [9:0]  ship_width_p      = 10'd40,
    parameter logic [9:0]  spawn_top_p       = 10'd440,
    parameter logic [9:0]  speed_p           = 10'd8,
    parameter logic [3:0]  cooldown_frames_p = 4'd15,
    parameter logic [11:0] color_p           = 12'hF00
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        frame_i,
    input  logic                        fire_i,
    input  logic [9:0]                  ship_left_i,
    input  logic [10*num_enemies_p-1:0] enemy_left_i,
    input  logic [10*num_enemies_p-1:0] enemy_right_i,
    input  logic [10*num_enemies_p-1:0] enemy_top_i,
    input  logic [10*num_enemies_p-1:0] enemy_bot_i,
    input  logic [num_enemies_p-1:0]    enemy_dead_i,
    output logic [num_enemies_p-1:0]    hit_o,
    output logic                        active_o,
    output logic [9:0]                  left_pos_o,
    output logic [9:0]                  right_pos_o,
    output logic [9:0]                  top_pos_o,
    output logic [9:0]                  bot_pos_o,
    output logic [3:0]                  missile_red_o,
    output logic [3:0]                  missile_green_o,
    output logic [3:0]                  missile_blue_o
);

    localparam logic [2:0] state_error_lp    = 3'b000;
    localparam logic [2:0] state_ready_lp    = 3'b001;
    localparam logic [2:0] state_flying_lp   = 3'b010;
    localparam logic [2:0] state_cooldown_lp = 3'b100;

    logic [2:0]               state_q, state_d;
    logic                     fire_prev_q;
    logic [num_enemies_p-1:0] hit_q, hit_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [9:0]               left_q, left_d, top_q, top_d;

    logic                     fire_edge;
    logic [9:0]               m_right, m_bot;
    logic [num_enemies_p-1:0] overlap, hit_sel;

    always_comb begin
        fire_edge = fire_i & ~fire_prev_q;
        m_right   = left_q + missile_width_p - 10'd1;
        m_bot     = top_q + missile_height_p - 10'd1;
        overlap   = '0;
        for (int i = 0; i < num_enemies_p; i++) begin
            overlap[i] = ~enemy_dead_i[i]
                       & (left_q  <= enemy_right_i[10*i +: 10])
                       & (m_right >= enemy_left_i[10*i +: 10])
                       & (top_q   <= enemy_bot_i[10*i +: 10])
                       & (m_bot   >= enemy_top_i[10*i +: 10]);
        end
        // Two's-complement trick isolates the lowest set bit: lowest index wins.
        hit_sel = overlap & (~overlap + 1'b1);
    end

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        hit_d   = '0;
        case (state_q)
            state_ready_lp: begin
                if (fire_edge) begin
                    left_d  = ship_left_i + (ship_width_p >> 1) - (missile_width_p >> 1);
                    top_d   = spawn_top_p;
                    state_d = state_flying_lp;
                end
            end
            state_flying_lp: begin
                if (|overlap) begin
                    hit_d   = hit_sel;
                    cnt_d   = cooldown_frames_p;
                    state_d = state_cooldown_lp;
                end else if (frame_i) begin
                    // Top edge would underflow: treat as leaving the screen.
                    if (top_q < speed_p) begin
                        cnt_d   = cooldown_frames_p;
                        state_d = state_cooldown_lp;
                    end else begin
                        top_d = top_q - speed_p;
                    end
                end
            end
            state_cooldown_lp: begin
                if (cnt_q == 4'd0) begin
                    state_d = state_ready_lp;
                end else if (frame_i) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = state_ready_lp;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= state_ready_lp;
            fire_prev_q <= 1'b0;
            hit_q       <= '0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            fire_prev_q <= fire_i;
            hit_q       <= hit_d;
            cnt_q       <= cnt_d;
        end
    end

    // Position registers are only observed while flying, so they need no reset.
    always_ff @(posedge clk_i) begin
        left_q <= left_d;
        top_q  <= top_d;
    end

    assign active_o        = (state_q == state_flying_lp);
    assign hit_o           = hit_q;
    assign left_pos_o      = active_o ? left_q  : 10'd0;
    assign right_pos_o     = active_o ? m_right : 10'd0;
    assign top_pos_o       = active_o ? top_q   : 10'd0;
    assign bot_pos_o       = active_o ? m_bot   : 10'd0;
    assign missile_red_o   = color_p[11:8];
    assign missile_green_o = color_p[7:4];
    assign missile_blue_o  = color_p[3:0];

endmodule

// File: tb/tb_player_missile.sv
// Bench for player_missile: table vectors, directed corner sequences and random
// traffic, all checked against a frame-level behavioural model of the missile.
module tb_player_missile;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_i, frame_i, fire_i;
    logic [9:0]     ship_left_i;
    logic [10*N-1:0] el, er, et, eb;
    logic [N-1:0]   dead;
    logic [N-1:0]   hit_o;
    logic           active_o;
    logic [9:0]     left_o, right_o, top_o, bot_o;
    logic [3:0]     red_o, green_o, blue_o;

    player_missile dut (
        .clk_i(clk), .reset_i(reset_i), .frame_i(frame_i), .fire_i(fire_i),
        .ship_left_i(ship_left_i),
        .enemy_left_i(el), .enemy_right_i(er), .enemy_top_i(et), .enemy_bot_i(eb),
        .enemy_dead_i(dead),
        .hit_o(hit_o), .active_o(active_o),
        .left_pos_o(left_o), .right_pos_o(right_o), .top_pos_o(top_o), .bot_pos_o(bot_o),
        .missile_red_o(red_o), .missile_green_o(green_o), .missile_blue_o(blue_o)
    );

    int vectors = 0;
    int miscompares = 0;
    int hits_seen = 0;

    // Behavioural model: mode 0 = waiting, 1 = in flight, 2 = recovering.
    int m_mode = 0, m_x = 0, m_y = 0, m_cd = 0, m_hit = 0;
    bit m_prev = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int first_overlap();
        for (int i = 0; i < N; i++) begin
            int l, r, t, b;
            l = int'(el[10*i +: 10]); r = int'(er[10*i +: 10]);
            t = int'(et[10*i +: 10]); b = int'(eb[10*i +: 10]);
            if (!dead[i] && m_x <= r && m_x + 3 >= l && m_y <= b && m_y + 9 >= t)
                return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit edge_seen;
        int k;
        edge_seen = fire_i && !m_prev;
        m_prev = fire_i;
        m_hit = 0;
        if (reset_i) begin
            m_mode = 0;
            m_prev = 0;
            return;
        end
        case (m_mode)
            0: if (edge_seen) begin
                m_x = int'(ship_left_i) + 20 - 2;
                m_y = 440;
                m_mode = 1;
            end
            1: begin
                k = first_overlap();
                if (k >= 0) begin
                    m_hit = 1 << k;
                    m_mode = 2;
                    m_cd = 15;
                end else if (frame_i) begin
                    if (m_y < 8) begin
                        m_mode = 2;
                        m_cd = 15;
                    end else begin
                        m_y = m_y - 8;
                    end
                end
            end
            default: begin
                if (m_cd == 0) m_mode = 0;
                else if (frame_i) m_cd--;
            end
        endcase
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        if (hit_o != '0) hits_seen++;
        chk("hit_o",    int'(hit_o),    m_hit);
        chk("active_o", int'(active_o), (m_mode == 1) ? 1 : 0);
        chk("left",     int'(left_o),   (m_mode == 1) ? m_x : 0);
        chk("right",    int'(right_o),  (m_mode == 1) ? m_x + 3 : 0);
        chk("top",      int'(top_o),    (m_mode == 1) ? m_y : 0);
        chk("bot",      int'(bot_o),    (m_mode == 1) ? m_y + 9 : 0);
    endtask

    task automatic set_enemy(input int i, input int l, input int r, input int t, input int b);
        el[10*i +: 10] = l[9:0];
        er[10*i +: 10] = r[9:0];
        et[10*i +: 10] = t[9:0];
        eb[10*i +: 10] = b[9:0];
    endtask

    task automatic do_reset();
        reset_i = 1'b1; fire_i = 1'b0; frame_i = 1'b0;
        cycle();
        reset_i = 1'b0;
        cycle();
    endtask

    task automatic frame_pulse();
        frame_i = 1'b1; cycle();
        frame_i = 1'b0; cycle();
    endtask

    typedef struct {
        int ship;
        int e0l, e0r, e0t, e0b;
        int e1l, e1r, e1t, e1b;
        logic [3:0] dmask;
        logic [3:0] exp_hit;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int launches, frames_n, last_top;
        bit prev_act, got_hit;

        tbl[0] = '{100, 100, 140, 430, 445, 100, 140, 430, 445, 4'b1100, 4'b0001};
        tbl[1] = '{100, 100, 140, 430, 445, 100, 140, 430, 445, 4'b1101, 4'b0010};
        tbl[2] = '{100, 100, 140, 430, 445, 100, 140, 430, 445, 4'b1111, 4'b0000};
        tbl[3] = '{0,   0,   18,  449, 460, 0,   17,  400, 500, 4'b1100, 4'b0001};
        tbl[4] = '{0,   0,   17,  449, 460, 19,  30,  450, 460, 4'b1100, 4'b0000};
        tbl[5] = '{100, 122, 130, 400, 440, 121, 130, 400, 440, 4'b1100, 4'b0010};
        tbl[6] = '{100, 100, 117, 400, 460, 50,  118, 441, 460, 4'b1100, 4'b0010};
        tbl[7] = '{100, 100, 140, 450, 460, 100, 140, 300, 439, 4'b1100, 4'b0000};

        reset_i = 1'b1; fire_i = 1'b0; frame_i = 1'b0;
        ship_left_i = 10'd0; el = '0; er = '0; et = '0; eb = '0; dead = '1;
        do_reset();
        chk("reset_active", int'(active_o), 0);
        chk("reset_hit", int'(hit_o), 0);
        chk("color_r", int'(red_o), 15);
        chk("color_g", int'(green_o), 0);
        chk("color_b", int'(blue_o), 0);

        // Launch, then a full miss through the top of the screen.
        ship_left_i = 10'd100;
        fire_i = 1'b1; cycle();
        chk("launch_active", int'(active_o), 1);
        chk("launch_left", int'(left_o), 118);
        chk("launch_right", int'(right_o), 121);
        chk("launch_top", int'(top_o), 440);
        chk("launch_bot", int'(bot_o), 449);
        fire_i = 1'b0; cycle();
        hits_seen = 0;
        for (int k = 0; k < 55; k++) frame_pulse();
        chk("miss_top0", int'(top_o), 0);
        chk("miss_still_active", int'(active_o), 1);
        frame_pulse();
        chk("miss_retired", int'(active_o), 0);
        chk("miss_no_hit", hits_seen, 0);
        fire_i = 1'b1; cycle(); fire_i = 1'b0; cycle();
        chk("cooldown_fire_ignored", int'(active_o), 0);
        for (int k = 0; k < 14; k++) frame_pulse();
        frame_i = 1'b1; cycle(); frame_i = 1'b0;
        fire_i = 1'b1; cycle();
        chk("edge_at_ready_ignored", int'(active_o), 0);
        cycle();
        chk("held_no_launch", int'(active_o), 0);
        fire_i = 1'b0; cycle();
        fire_i = 1'b1; cycle();
        chk("fresh_edge_launch", int'(active_o), 1);
        fire_i = 1'b0;

        // Reset at the tenth frame of a flight.
        for (int k = 0; k < 9; k++) frame_pulse();
        frame_i = 1'b1; reset_i = 1'b1; cycle();
        reset_i = 1'b0; frame_i = 1'b0;
        chk("rst_active", int'(active_o), 0);
        chk("rst_hit", int'(hit_o), 0);
        chk("rst_left", int'(left_o), 0);
        chk("rst_top", int'(top_o), 0);
        cycle();

        // Slot 2 hit while climbing.
        do_reset();
        dead = 4'b1011;
        set_enemy(2, 110, 150, 200, 210);
        ship_left_i = 10'd100;
        fire_i = 1'b1; cycle(); fire_i = 1'b0; cycle();
        got_hit = 0; frames_n = 0; last_top = 0;
        for (int k = 0; k < 40 && !got_hit; k++) begin
            frame_i = 1'b1; cycle(); frame_i = 1'b0; frames_n++;
            last_top = int'(top_o);
            cycle();
            if (hit_o != '0) begin
                got_hit = 1;
                chk("hit_slot2", int'(hit_o), 4);
                chk("hit_inactive", int'(active_o), 0);
                chk("hit_top", last_top, 208);
                chk("hit_frames", frames_n, 29);
                cycle();
                chk("hit_one_cycle", int'(hit_o), 0);
            end
        end
        chk("hit_seen", int'(got_hit), 1);

        // Table: launch-box overlaps, priority, dead mask, inclusive edges.
        foreach (tbl[v]) begin
            do_reset();
            dead = tbl[v].dmask;
            set_enemy(0, tbl[v].e0l, tbl[v].e0r, tbl[v].e0t, tbl[v].e0b);
            set_enemy(1, tbl[v].e1l, tbl[v].e1r, tbl[v].e1t, tbl[v].e1b);
            ship_left_i = tbl[v].ship[9:0];
            fire_i = 1'b1; cycle(); fire_i = 1'b0; cycle();
            chk($sformatf("tbl%0d_hit", v), int'(hit_o), int'(tbl[v].exp_hit));
        end

        // Fire held for a long time launches exactly once.
        do_reset();
        dead = '1;
        fire_i = 1'b1; launches = 0; prev_act = 0;
        for (int k = 0; k < 400; k++) begin
            frame_i = (k % 2 == 0);
            cycle();
            if (active_o && !prev_act) launches++;
            prev_act = active_o;
        end
        fire_i = 1'b0; frame_i = 1'b0;
        chk("held_fire_launches", launches, 1);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            if (k % 60 == 0) begin
                for (int i = 0; i < N; i++) begin
                    int l, t;
                    l = $urandom_range(0, 600);
                    t = $urandom_range(0, 460);
                    set_enemy(i, l, l + $urandom_range(0, 60), t, t + $urandom_range(0, 30));
                end
                dead = N'($urandom);
                ship_left_i = 10'($urandom_range(0, 600));
            end
            frame_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) fire_i = ~fire_i;
            reset_i = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
